// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: register-driven start, SCLK/MOSI/SS generation, RX push.
// Define SPI_XFER_CTRL_LOOPBACK_EN to sample the MOSI line instead of miso_i.
module spi_xfer_ctrl (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] reg_control_i,
    input  logic [31:0] reg_trans_ctrl_i,
    input  logic [31:0] tx_data_i,
    input  logic        tx_empty_i,
    input  logic        rx_full_i,
    input  logic        miso_i,
    output logic        tx_rd_o,
    output logic        rx_wr_o,
    output logic [31:0] rx_data_o,
    output logic        trans_start_o,
    output logic        spi_busy_o,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic [3:0]  ss_n_o
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, STORE} state_t;

    state_t      state;
    logic [3:0]  hp_q;
    logic [3:0]  cnt;
    logic        cpol_q;
    logic        cpha_q;
    logic        msb_q;
    logic [1:0]  len_q;
    logic [3:0]  mask_q;
    logic [31:0] tx_q;
    logic [31:0] rx_q;
    logic [5:0]  half;

    logic [5:0]  nbits;
    logic [5:0]  n_in;
    logic [5:0]  drive_idx;
    logic [5:0]  sel;
    logic [5:0]  first_sel;
    logic        last_cnt;
    logic        last_half;
    logic        lead;
    logic        sbit;
    logic        go;

    function automatic logic [5:0] len_to_n(input logic [1:0] len);
        unique case (len)
            2'b01:   len_to_n = 6'd16;
            2'b10:   len_to_n = 6'd32;
            default: len_to_n = 6'd8;
        endcase
    endfunction

    always_comb begin
        nbits     = len_to_n(len_q);
        n_in      = len_to_n(reg_trans_ctrl_i[6:5]);
        last_cnt  = (cnt == hp_q);
        last_half = ({1'b0, half} == ({nbits, 1'b0} - 7'd1));
        lead      = ~half[0];
        // CPHA=0 already put bit 0 out in SETUP, so trailing edges drive the next one
        drive_idx = {1'b0, half[5:1]} + {5'd0, ~cpha_q};
        sel       = msb_q ? (nbits - 6'd1 - drive_idx) : drive_idx;
        first_sel = reg_control_i[8] ? (n_in - 6'd1) : 6'd0;
        go        = reg_trans_ctrl_i[13] & ~tx_empty_i;
    end

`ifdef SPI_XFER_CTRL_LOOPBACK_EN
    assign sbit = mosi_o;
    logic unused_bits;
    assign unused_bits = ^{reg_control_i[31:11], reg_control_i[7:4],
                           reg_trans_ctrl_i[31:14], reg_trans_ctrl_i[12:7],
                           reg_trans_ctrl_i[4], sel[5], first_sel[5], miso_i};
`else
    assign sbit = miso_i;
    logic unused_bits;
    assign unused_bits = ^{reg_control_i[31:11], reg_control_i[7:4],
                           reg_trans_ctrl_i[31:14], reg_trans_ctrl_i[12:7],
                           reg_trans_ctrl_i[4], sel[5], first_sel[5]};
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= IDLE;
            hp_q          <= 4'd0;
            cnt           <= 4'd0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            msb_q         <= 1'b0;
            len_q         <= 2'b00;
            mask_q        <= 4'd0;
            tx_q          <= 32'd0;
            rx_q          <= 32'd0;
            half          <= 6'd0;
            tx_rd_o       <= 1'b0;
            rx_wr_o       <= 1'b0;
            rx_data_o     <= 32'd0;
            trans_start_o <= 1'b0;
            spi_busy_o    <= 1'b0;
            sclk_o        <= 1'b0;
            mosi_o        <= 1'b0;
            ss_n_o        <= 4'hF;
        end else begin
            tx_rd_o       <= 1'b0;
            rx_wr_o       <= 1'b0;
            trans_start_o <= 1'b0;
            spi_busy_o    <= (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state         <= SETUP;
                        trans_start_o <= 1'b1;
                        tx_rd_o       <= 1'b1;
                        tx_q          <= tx_data_i;
                        rx_q          <= 32'd0;
                        hp_q          <= (reg_control_i[3:0] == 4'd0) ?
                                         4'd0 : reg_control_i[3:0] - 4'd1;
                        msb_q         <= reg_control_i[8];
                        cpol_q        <= reg_control_i[9];
                        cpha_q        <= reg_control_i[10];
                        len_q         <= reg_trans_ctrl_i[6:5];
                        mask_q        <= reg_trans_ctrl_i[3:0];
                        cnt           <= 4'd0;
                        half          <= 6'd0;
                        sclk_o        <= reg_control_i[9];
                        ss_n_o        <= ~reg_trans_ctrl_i[3:0];
                        if (!reg_control_i[10])
                            mosi_o <= tx_data_i[first_sel[4:0]];
                    end
                end
                SETUP: begin
                    cnt <= last_cnt ? 4'd0 : cnt + 4'd1;
                    if (last_cnt)
                        state <= SHIFT;
                end
                SHIFT: begin
                    cnt <= last_cnt ? 4'd0 : cnt + 4'd1;
                    if (last_cnt) begin
                        sclk_o <= ~sclk_o;
                        if (lead != cpha_q) begin
                            if (msb_q)
                                rx_q <= {rx_q[30:0], sbit};
                            else
                                rx_q[half[5:1]] <= sbit;
                        end else if (drive_idx != nbits) begin
                            mosi_o <= tx_q[sel[4:0]];
                        end
                        if (last_half) begin
                            half  <= 6'd0;
                            state <= HOLD;
                        end else begin
                            half <= half + 6'd1;
                        end
                    end
                end
                HOLD: begin
                    cnt <= last_cnt ? 4'd0 : cnt + 4'd1;
                    if (last_cnt)
                        state <= STORE;
                end
                STORE: begin
                    if (!rx_full_i) begin
                        rx_wr_o   <= 1'b1;
                        rx_data_o <= rx_q;
                        ss_n_o    <= 4'hF;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (state != IDLE && mask_q == 4'd0)
                ss_n_o <= 4'hF;
        end
    end

endmodule
